prefix_or_scan: RTL and testbench

Sequential, parametrised prefix-OR reducer. For each request it reports whether any bit in the low `len` bits of a data word is set, and the index of the lowest such bit. It scans `CHUNK` bits per cycle and stops early on the first hit. Requests and results use valid/ready handshakes, so it can sit between a taint-tracked source register and a downstream consumer.

---
 rtl/prefix_or_scan.sv | 207 ++++++++++++++++++++
 tb/tb_prefix_or_scan.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/prefix_or_scan.sv
// prefix_or_scan
//
// Sequential prefix-OR reducer. Each request asks whether any bit in the low
// in_len bits of in_data is set, and for the index of the lowest such bit.
// The captured word is examined CHUNK bits per cycle, and the scan stops at
// the first chunk that contains a hit.
//
// Parameters:
//   DATA_W - data word width (>= 1)
//   LEN_W  - width of in_len / out_idx (>= clog2(DATA_W+1))
//   CHUNK  - bits examined per scan cycle (1..DATA_W)
//
// Ports:
//   clk          - clock, rising edge
//   rst_n        - asynchronous active-low reset
//   in_valid     - request present
//   in_ready     - block can accept a request (decoded from state)
//   in_len       - prefix length; bits [in_len-1:0] are examined
//   in_data      - data word
//   out_valid    - result present
//   out_ready    - consumer takes the result
//   out_bit      - OR of the prefix bits
//   out_idx      - index of the lowest set prefix bit, 0 if none
//   out_len_err  - in_len exceeded DATA_W and was clamped
module prefix_or_scan #(
    parameter int DATA_W = 27,
    parameter int LEN_W  = 5,
    parameter int CHUNK  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LEN_W-1:0]  in_len,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic [LEN_W-1:0]  out_idx,
    output logic              out_len_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] DATA_W_L = LEN_W'(DATA_W);

    state_t             state;
    state_t             stateNext;

    logic [DATA_W-1:0]  dataReg;
    logic [LEN_W-1:0]   lenEff;
    logic               errReg;
    logic [LEN_W-1:0]   pos;

    logic               outValidReg;
    logic               outBitReg;
    logic [LEN_W-1:0]   outIdxReg;
    logic               outErrReg;

    logic [LEN_W-1:0]   lenClamp;
    logic               lenOver;
    logic [DATA_W-1:0]  windowMask;
    logic [DATA_W-1:0]  windowHits;
    logic               hitFound;
    logic [LEN_W-1:0]   hitIdx;
    logic               lastChunk;

    // Clamp the requested length to the word width and remember whether
    // clamping happened, so the result can flag a malformed request.
    always_comb begin
        lenOver  = (in_len > DATA_W_L);
        lenClamp = lenOver ? DATA_W_L : in_len;
    end

    // The current window is bits [pos, pos+CHUNK-1] of the captured word,
    // further limited to the prefix. Building the mask across the full word
    // means positions past the top of the word simply have no mask bit, so
    // nothing is ever indexed out of range.
    always_comb begin
        windowMask = '0;
        for (int j = 0; j < DATA_W; j++) begin
            windowMask[j] = (32'(j) >= 32'(pos)) &&
                            (32'(j) < 32'(pos) + 32'(CHUNK)) &&
                            (32'(j) < 32'(lenEff));
        end
        windowHits = dataReg & windowMask;
    end

    // Priority pick of the lowest set bit in the window; walking downward
    // lets the lowest index be the last (and therefore winning) assignment.
    always_comb begin
        hitFound = 1'b0;
        hitIdx   = '0;
        for (int j = DATA_W - 1; j >= 0; j--) begin
            if (windowHits[j]) begin
                hitFound = 1'b1;
                hitIdx   = LEN_W'(j);
            end
        end
        lastChunk = (32'(pos) + 32'(CHUNK)) >= 32'(lenEff);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic. A zero-length request needs no scanning and goes
    // straight to DONE; otherwise the scan ends on a hit or on the chunk
    // that reaches the end of the prefix.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    stateNext = (lenClamp == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (hitFound || lastChunk) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Output decode: the block accepts work only while idle.
    always_comb begin
        in_ready = (state == IDLE);
    end

    // Datapath and result registers. The result registers are written only
    // when a new result is produced, so they keep their value after the
    // consumer takes it; out_valid alone is dropped on the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataReg     <= '0;
            lenEff      <= '0;
            errReg      <= 1'b0;
            pos         <= '0;
            outValidReg <= 1'b0;
            outBitReg   <= 1'b0;
            outIdxReg   <= '0;
            outErrReg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dataReg <= in_data;
                        lenEff  <= lenClamp;
                        errReg  <= lenOver;
                        pos     <= '0;
                        if (lenClamp == '0) begin
                            outValidReg <= 1'b1;
                            outBitReg   <= 1'b0;
                            outIdxReg   <= '0;
                            outErrReg   <= lenOver;
                        end
                    end
                end
                SCAN: begin
                    if (hitFound) begin
                        outValidReg <= 1'b1;
                        outBitReg   <= 1'b1;
                        outIdxReg   <= hitIdx;
                        outErrReg   <= errReg;
                    end else if (lastChunk) begin
                        outValidReg <= 1'b1;
                        outBitReg   <= 1'b0;
                        outIdxReg   <= '0;
                        outErrReg   <= errReg;
                    end else begin
                        pos <= pos + LEN_W'(CHUNK);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValidReg <= 1'b0;
                    end
                end
                default: begin
                    outValidReg <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid   = outValidReg;
    assign out_bit     = outBitReg;
    assign out_idx     = outIdxReg;
    assign out_len_err = outErrReg;

endmodule

// File: tb/tb_prefix_or_scan.sv
// tb_prefix_or_scan
//
// Directed testbench for prefix_or_scan with DATA_W = 27, LEN_W = 5,
// CHUNK = 4. Each step drives a request, measures how many edges after the
// accepting edge the result appears, and compares the result against
// hand-computed values.
module tb_prefix_or_scan;

    localparam int DATA_W = 27;
    localparam int LEN_W  = 5;
    localparam int CHUNK  = 4;
    localparam int MAX_WAIT = 50;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [LEN_W-1:0]  in_len;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_bit;
    logic [LEN_W-1:0]  out_idx;
    logic              out_len_err;

    int total;
    int bad;
    int latency;

    prefix_or_scan #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W),
        .CHUNK  (CHUNK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_len      (in_len),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bit     (out_bit),
        .out_idx     (out_idx),
        .out_len_err (out_len_err)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and on a miss counts the failure and
    // reports the tag with observed and expected values.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Present a request while idle, then count edges after the accepting
    // edge until out_valid shows up. Inputs are scrambled right after
    // acceptance to show the block works from its captured copy.
    task automatic applyStimulus(input logic [LEN_W-1:0] len,
                                 input logic [DATA_W-1:0] data,
                                 output int cycles);
        in_valid = 1'b1;
        in_len   = len;
        in_data  = data;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_len   = LEN_W'($urandom);
        in_data  = DATA_W'($urandom);
        cycles   = 0;
        while (!out_valid && cycles < MAX_WAIT) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("no_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    // Consume the current result with a one-cycle out_ready pulse.
    task automatic takeResult();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // Run one request and check result fields and latency.
    task automatic runCase(input string tag, input logic [LEN_W-1:0] len,
                           input logic [DATA_W-1:0] data, input logic expBit,
                           input int expIdx, input logic expErr, input int expN);
        int n;
        applyStimulus(len, data, n);
        $display("[TB] %s: latency=%0d bit=%0d idx=%0d err=%0d", tag, n,
                 out_bit, out_idx, out_len_err);
        checkOutput({tag, "_bit"}, {31'd0, out_bit}, {31'd0, expBit});
        checkOutput({tag, "_idx"}, {27'd0, out_idx}, 32'(expIdx));
        checkOutput({tag, "_err"}, {31'd0, out_len_err}, {31'd0, expErr});
        checkOutput({tag, "_n"}, 32'(n), 32'(expN));
        takeResult();
        checkOutput({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        checkOutput({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_len    = '0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_bit", {31'd0, out_bit}, 32'd0);
        checkOutput("rst_out_idx", {27'd0, out_idx}, 32'd0);
        checkOutput("rst_out_err", {31'd0, out_len_err}, 32'd0);

        // Zero and unit lengths.
        runCase("len0", 5'd0, 27'h7FFFFFF, 1'b0, 0, 1'b0, 0);
        runCase("len1", 5'd1, 27'd1, 1'b1, 0, 1'b0, 1);

        // Full-width hit in the top bit: chunk 6 holds bit 26.
        runCase("top", 5'd27, 27'h4000000, 1'b1, 26, 1'b0, 7);

        // Bit just outside a 10-bit prefix: three chunks, miss.
        runCase("outside", 5'd10, 27'h0000400, 1'b0, 0, 1'b0, 3);

        // Two set bits (5 and 8): lowest wins, found in chunk 1.
        runCase("lowest", 5'd27, 27'h0000120, 1'b1, 5, 1'b0, 2);

        // Length 31 clamps to 27 and flags the error; seven chunks, miss.
        runCase("clamp", 5'd31, 27'd0, 1'b0, 0, 1'b1, 7);

        // Backpressure: result for bit 6 held while out_ready stays low,
        // with an in_valid pulse that must be ignored.
        begin
            int n;
            applyStimulus(5'd8, 27'h0000040, n);
            checkOutput("bp_n", 32'(n), 32'd2);
            for (int c = 0; c < 5; c++) begin
                if (c == 2) begin
                    in_valid = 1'b1;
                    in_len   = 5'd4;
                    in_data  = 27'h1;
                end
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
                checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
                checkOutput("bp_bit", {31'd0, out_bit}, 32'd1);
                checkOutput("bp_idx", {27'd0, out_idx}, 32'd6);
            end
            takeResult();
            checkOutput("bp_valid_drop", {31'd0, out_valid}, 32'd0);
            checkOutput("bp_idx_hold", {27'd0, out_idx}, 32'd6);
            checkOutput("bp_bit_hold", {31'd0, out_bit}, 32'd1);
            // No stray transaction from the ignored pulse.
            repeat (3) @(posedge clk);
            #1;
            checkOutput("bp_no_stray", {31'd0, out_valid}, 32'd0);
        end

        // Reset mid-scan of an all-zero full-width word.
        in_valid = 1'b1;
        in_len   = 5'd27;
        in_data  = 27'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid_scan_busy", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_idx", {27'd0, out_idx}, 32'd0);
        checkOutput("mid_rst_bit", {31'd0, out_bit}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checkOutput("mid_rst_hold_valid", {31'd0, out_valid}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            checkOutput("post_rst_quiet", {31'd0, out_valid}, 32'd0);
        end

        // The next request completes normally: bit 13 sits in chunk 3.
        runCase("after_rst", 5'd27, 27'h0002000, 1'b1, 13, 1'b0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
